// File: rtl/reset_sequencer_pkg.sv
// Shared types for the board reset sequencer: FSM state encoding and retry counter width.
package reset_sequencer_pkg;

  localparam int unsigned RETRY_W = 2;

  typedef enum logic [2:0] {
    S_PLL_RST    = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_PERIPH_REL = 3'd2,
    S_RUN        = 3'd3,
    S_FAULT      = 3'd4
  } state_t;

endpackage

// File: rtl/reset_sequencer_debouncer.sv
// Pushbutton conditioner: 2-flop synchronizer followed by a consecutive-sample debouncer.
// pressed is the debounced, active-high view of the active-low button.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned WIDTH_CNT       = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic button_n,
  output logic pressed
);

  logic                 sync_1;
  logic                 sync_2;
  logic                 level;
  logic [WIDTH_CNT-1:0] cnt;

  // Two-stage synchronizer for the asynchronous button input
  always_ff @(posedge clk) begin
    sync_1 <= button_n;
    sync_2 <= sync_1;
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync_2 == level) begin
      cnt <= '0;
    end else if (cnt == WIDTH_CNT'(DEBOUNCE_CYCLES - 1)) begin
      level <= sync_2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + WIDTH_CNT'(1);
    end
  end

  assign pressed = ~level;

endmodule

// File: rtl/reset_sequencer.sv
// Board reset and clock bring-up sequencer: drives PLL areset, waits for stable lock with
// timeout and bounded retries, then releases peripheral and SoC resets in order.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = 500000,
  parameter int unsigned PLL_RESET_CYCLES    = 64,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned RELEASE_GAP_CYCLES  = 16,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned WIDTH_CNT           = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               button_n,
  input  logic               pll_locked,
  output logic               pll_areset,
  output logic               periph_reset,
  output logic               soc_reset,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count
);

  state_t               state;
  state_t               state_next;
  logic [RETRY_W-1:0]   retry_next;
  logic [WIDTH_CNT-1:0] timer;
  logic [WIDTH_CNT-1:0] stable;
  logic                 locked_s1;
  logic                 locked_s2;
  logic                 pressed;
  logic                 restart;
  logic                 timing;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .WIDTH_CNT       (WIDTH_CNT)
  ) u_debouncer (
    .clk      (clk),
    .reset    (reset),
    .button_n (button_n),
    .pressed  (pressed)
  );

  // Two-stage synchronizer for the asynchronous PLL lock flag
  always_ff @(posedge clk) begin
    locked_s1 <= pll_locked;
    locked_s2 <= locked_s1;
  end

  // Next-state logic; button beats lock loss, lock loss beats timer expiry
  always_comb begin
    state_next = state;
    retry_next = retry_count;
    unique case (state)
      S_PLL_RST: begin
        if (timer == WIDTH_CNT'(PLL_RESET_CYCLES - 1)) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s2 && (stable == WIDTH_CNT'(LOCK_STABLE_CYCLES - 1))) begin
          state_next = S_PERIPH_REL;
        end else if (timer == WIDTH_CNT'(LOCK_TIMEOUT_CYCLES - 1)) begin
          if (retry_count < RETRY_W'(MAX_RETRIES)) begin
            retry_next = retry_count + RETRY_W'(1);
            state_next = S_PLL_RST;
          end else begin
            state_next = S_FAULT;
          end
        end
      end
      S_PERIPH_REL: begin
        if (!locked_s2) state_next = S_PLL_RST;
        else if (timer == WIDTH_CNT'(RELEASE_GAP_CYCLES - 1)) state_next = S_RUN;
      end
      S_RUN: begin
        if (!locked_s2) state_next = S_PLL_RST;
      end
      S_FAULT: begin
        state_next = S_FAULT;
      end
      default: state_next = S_PLL_RST;
    endcase
    if (pressed) begin
      state_next = S_PLL_RST;
      retry_next = '0;
    end
  end

  assign restart = pressed || (state_next != state);
  assign timing  = (state == S_PLL_RST) || (state == S_WAIT_LOCK) || (state == S_PERIPH_REL);

  // Shared phase timer: restarts on every transition and is held at zero while the button is down
  always_ff @(posedge clk) begin
    if (reset || restart) timer <= '0;
    else if (timing)      timer <= timer + WIDTH_CNT'(1);
  end

  // Consecutive synchronized-lock counter, only live while waiting for lock
  always_ff @(posedge clk) begin
    if (reset || (state != S_WAIT_LOCK) || !locked_s2) stable <= '0;
    else                                                stable <= stable + WIDTH_CNT'(1);
  end

  // State, retry counter and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_PLL_RST;
      retry_count  <= '0;
      pll_areset   <= 1'b1;
      periph_reset <= 1'b1;
      soc_reset    <= 1'b1;
      ready        <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_next;
      retry_count  <= retry_next;
      pll_areset   <= (state_next == S_PLL_RST) || (state_next == S_FAULT);
      periph_reset <= !((state_next == S_PERIPH_REL) || (state_next == S_RUN));
      soc_reset    <= (state_next != S_RUN);
      ready        <= (state_next == S_RUN);
      fault        <= (state_next == S_FAULT);
    end
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Board-level reset and clock-bring-up controller on the raw board clock, ahead of the PLL and the SoC. Debounces the reset pushbutton and drives the PLL areset. Waits for a stable PLL lock, with a timeout and bounded retries. Releases peripheral and CPU resets in order, and restarts the sequence on lock loss or a button press.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive synchronized samples needed to accept a button level change.
- PLL_RESET_CYCLES, 64: pll_areset pulse length, in cycles.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before lock is accepted.
- LOCK_TIMEOUT_CYCLES, 1000000: cycles allowed in S_WAIT_LOCK before a timeout.
- RELEASE_GAP_CYCLES, 16: cycles between periph_reset release and soc_reset release.
- MAX_RETRIES, 3: timeouts tolerated before S_FAULT.
- WIDTH_CNT, 24: shared timer width. Must hold the largest cycle parameter.

Ports:
- clk, input, 1: board clock (SYS_CLK). One clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high.
- button_n, input, 1: raw pushbutton, active-low, asynchronous.
- pll_locked, input, 1: PLL lock flag, asynchronous.
- pll_areset, output, 1: PLL reset, active-high.
- periph_reset, output, 1: UART/I2C/timer reset, active-high.
- soc_reset, output, 1: CPU/SoC reset, active-high.
- ready, output, 1: sequence complete, system running.
- fault, output, 1: retries exhausted.
- retry_count, output, 2: timeouts since the last restart, saturating.

## Operation
- button_n and pll_locked each pass through a 2-flop synchronizer.
- Debouncer: the level toggles after DEBOUNCE_CYCLES consecutive equal samples that differ from the current level. The debounced level resets to released.
- States:
  - S_PLL_RST: pll_areset=1. After PLL_RESET_CYCLES, go to S_WAIT_LOCK.
  - S_WAIT_LOCK:
    - Stable counter increments while synced locked=1 and clears on 0.
    - Reaching LOCK_STABLE_CYCLES goes to S_PERIPH_REL.
    - Timeout with retry_count<MAX_RETRIES: retry_count+1, go to S_PLL_RST.
    - Timeout with retry_count=MAX_RETRIES: go to S_FAULT.
  - S_PERIPH_REL: periph_reset=0. After RELEASE_GAP_CYCLES, go to S_RUN.
  - S_RUN: soc_reset=0, ready=1.
  - S_FAULT: pll_areset=1, fault=1. Held until a button press.
- Lock loss: synced locked=0 in S_PERIPH_REL or S_RUN goes to S_PLL_RST. retry_count is unchanged and the loss is not counted.
- Button: a debounced pressed level in any state forces S_PLL_RST with the timer reloaded and retry_count cleared.
  - Stays in S_PLL_RST while held.
  - The PLL_RESET_CYCLES count starts after the debounced release.
- Simultaneous events: button overrides lock loss. Lock loss overrides timer expiry.
- Outputs per state:
  - S_PLL_RST, S_WAIT_LOCK, S_FAULT: periph_reset=1 and soc_reset=1.
  - S_PERIPH_REL: soc_reset=1.
- Consumers in the PLL clock domain re-synchronize soc_reset and periph_reset with 2 flops.

## Timing
- Reset values: pll_areset=1, periph_reset=1, soc_reset=1, ready=0, fault=0, retry_count=0. State S_PLL_RST with the timer cleared.
- All outputs are registered and decoded from the next state, so they change in the cycle after the state transition.
- pll_areset is high for exactly PLL_RESET_CYCLES cycles after reset deasserts, unless interrupted by a button press.
- Lock latency: 2 synchronizer cycles + LOCK_STABLE_CYCLES from a steady pll_locked to the S_PERIPH_REL entry.
- Lock loss: 2 synchronizer cycles + 1 registered cycle from a pll_locked fall until ready=0, soc_reset=1 and periph_reset=1.
- Reset asserted mid-sequence: all outputs return to their reset values on the next edge.

## Structure
- reset_sequencer_pkg holds the state enum (S_PLL_RST, S_WAIT_LOCK, S_PERIPH_REL, S_RUN, S_FAULT) and the retry_count width.
- One sub-module, button_debouncer: 2-flop synchronizer, counter of width WIDTH_CNT, and debounced-level output.
- Main FSM: one shared WIDTH_CNT timer, a separate stable counter, and the retry counter.

## Test plan
All scenarios use DEBOUNCE=5, PLL_RESET=4, LOCK_STABLE=8, LOCK_TIMEOUT=100, RELEASE_GAP=3, MAX_RETRIES=2.
- Nominal bring-up: pll_locked high from cycle 0, button released.
  - pll_areset low after exactly 4 cycles.
  - periph_reset low, then soc_reset low and ready=1 three cycles later.
- Lock glitches: locked drops for 1 cycle every 6 cycles, so it is never stable for 8.
  - Timeouts repeat; retry_count steps 1, 2.
  - On the third timeout, fault=1 and pll_areset=1.
- Lock loss in S_RUN: drop pll_locked for 1 cycle.
  - ready=0 and both resets=1 three cycles later.
  - The sequence reruns with retry_count still 0.
- Button bounce: 3-cycle low pulses produce no effect.
  - A 5-cycle-plus low press from S_RUN forces S_PLL_RST; pll_areset is held while pressed.
  - After the debounced release, pll_areset lasts 4 cycles.
- Button out of S_FAULT: a debounced press clears fault and retry_count, and a nominal bring-up completes.
- Reset in S_PERIPH_REL: assert reset for 1 cycle; all outputs return to reset values on the next edge.
